// File: rtl/tlb_entry_array_if.sv
// tlb_entry_array_if: lookup, refill, flush and occupancy bundle for the TLB entry array
//    master: drives req_*, refill_* and flush_*; receives resp_* and occupancy
//    slave : the entry array side
interface tlb_entry_array_if #(
   parameter int ENTRIES  = 4,
   parameter int VPN_BITS = 20,
   parameter int PPN_BITS = 20
);
   logic                    req_valid;
   logic [VPN_BITS-1:0]     req_vpn;
   logic                    resp_valid;
   logic                    resp_hit;
   logic [PPN_BITS-1:0]     resp_ppn;
   logic                    resp_u, resp_g, resp_ae, resp_sw, resp_sx, resp_sr, resp_pw;
   logic                    resp_px, resp_pr, resp_pal, resp_paa, resp_eff, resp_c;
   logic                    resp_fragmented_superpage;
   logic                    refill_valid;
   logic [VPN_BITS-1:0]     refill_vpn;
   logic [PPN_BITS-1:0]     refill_ppn;
   logic                    refill_u, refill_g, refill_ae, refill_sw, refill_sx, refill_sr, refill_pw;
   logic                    refill_px, refill_pr, refill_pal, refill_paa, refill_eff, refill_c;
   logic                    refill_fragmented_superpage;
   logic                    flush_valid;
   logic                    flush_all;
   logic [VPN_BITS-1:0]     flush_vpn;
   logic [$clog2(ENTRIES):0] occupancy;
   modport master (
      output req_valid, req_vpn,
      output refill_valid, refill_vpn, refill_ppn,
      output refill_u, refill_g, refill_ae, refill_sw, refill_sx, refill_sr, refill_pw,
      output refill_px, refill_pr, refill_pal, refill_paa, refill_eff, refill_c, refill_fragmented_superpage,
      output flush_valid, flush_all, flush_vpn,
      input  resp_valid, resp_hit, resp_ppn,
      input  resp_u, resp_g, resp_ae, resp_sw, resp_sx, resp_sr, resp_pw,
      input  resp_px, resp_pr, resp_pal, resp_paa, resp_eff, resp_c, resp_fragmented_superpage,
      input  occupancy
   );
   modport slave (
      input  req_valid, req_vpn,
      input  refill_valid, refill_vpn, refill_ppn,
      input  refill_u, refill_g, refill_ae, refill_sw, refill_sx, refill_sr, refill_pw,
      input  refill_px, refill_pr, refill_pal, refill_paa, refill_eff, refill_c, refill_fragmented_superpage,
      input  flush_valid, flush_all, flush_vpn,
      output resp_valid, resp_hit, resp_ppn,
      output resp_u, resp_g, resp_ae, resp_sw, resp_sx, resp_sr, resp_pw,
      output resp_px, resp_pr, resp_pal, resp_paa, resp_eff, resp_c, resp_fragmented_superpage,
      output occupancy
   );
endinterface

// File: rtl/tlb_entry_array.sv
// tlb_entry_array: fully-associative TLB store with registered lookup, refill and SFENCE flush
//    clock : sole clock
//    reset : synchronous active-high
//    bus   : tlb_entry_array_if.slave (lookup request/response, refill, flush, occupancy)
module tlb_entry_array #(
   parameter int ENTRIES  = 4,
   parameter int VPN_BITS = 20,
   parameter int PPN_BITS = 20
) (
   input logic               clock,
   input logic               reset,
   tlb_entry_array_if.slave  bus
);
   localparam int IW = $clog2(ENTRIES);
   localparam int FW = 14;
   logic [ENTRIES-1:0]  r_valid;
   logic [VPN_BITS-1:0] r_vpn   [ENTRIES];
   logic [PPN_BITS-1:0] r_ppn   [ENTRIES];
   logic [FW-1:0]       r_flags [ENTRIES];
   logic [IW-1:0]       r_rr_ptr;
   logic                r_resp_valid;
   logic                r_resp_hit;
   logic [PPN_BITS-1:0] r_resp_ppn;
   logic [FW-1:0]       r_resp_flags;
   logic [ENTRIES-1:0]  w_hit_vec, w_refill_match, w_flush_match;
   logic [PPN_BITS-1:0] w_hit_ppn;
   logic [FW-1:0]       w_hit_flags, w_refill_flags;
   logic [IW-1:0]       w_victim;
   logic                w_use_rr;
   logic [IW:0]         w_occupancy;
   logic                w_write;
   assign w_refill_flags = {bus.refill_u, bus.refill_g, bus.refill_ae, bus.refill_sw, bus.refill_sx,
                            bus.refill_sr, bus.refill_pw, bus.refill_px, bus.refill_pr, bus.refill_pal,
                            bus.refill_paa, bus.refill_eff, bus.refill_c, bus.refill_fragmented_superpage};
   // flush takes priority: a refill in a flush cycle is dropped entirely
   assign w_write = bus.refill_valid && !bus.flush_valid;
   always_comb begin
      w_hit_vec      = '0;
      w_refill_match = '0;
      w_flush_match  = '0;
      w_hit_ppn      = '0;
      w_hit_flags    = '0;
      w_occupancy    = '0;
      w_victim       = r_rr_ptr;
      w_use_rr       = 1'b1;
      // descending scan so the lowest-index invalid entry is the one left in w_victim
      for (int i = ENTRIES-1; i >= 0; i--) begin
         w_hit_vec[i]      = r_valid[i] && r_vpn[i] == bus.req_vpn;
         w_refill_match[i] = r_valid[i] && r_vpn[i] == bus.refill_vpn;
         w_flush_match[i]  = r_valid[i] && r_vpn[i] == bus.flush_vpn;
         // refill never duplicates tags, so OR-ing the single matching entry is a mux
         w_hit_ppn   = w_hit_ppn   | (w_hit_vec[i] ? r_ppn[i]   : '0);
         w_hit_flags = w_hit_flags | (w_hit_vec[i] ? r_flags[i] : '0);
         w_occupancy = w_occupancy + (IW+1)'(r_valid[i]);
         if (!r_valid[i]) begin
            w_victim = IW'(i);
            w_use_rr = 1'b0;
         end
      end
      // an existing entry for the same VPN outranks any free slot
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (w_refill_match[i]) begin
            w_victim = IW'(i);
            w_use_rr = 1'b0;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid      <= '0;
         r_rr_ptr     <= '0;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_ppn   <= '0;
         r_resp_flags <= '0;
      end else begin
         r_resp_valid <= bus.req_valid;
         r_resp_hit   <= bus.req_valid && |w_hit_vec;
         r_resp_ppn   <= bus.req_valid ? w_hit_ppn : '0;
         r_resp_flags <= bus.req_valid ? w_hit_flags : '0;
         if (bus.flush_valid) begin
            r_valid <= bus.flush_all ? '0 : r_valid & ~w_flush_match;
         end else if (bus.refill_valid) begin
            r_valid[w_victim] <= 1'b1;
            if (w_use_rr) r_rr_ptr <= r_rr_ptr + 1'b1;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (!reset && w_write) begin
         r_vpn[w_victim]   <= bus.refill_vpn;
         r_ppn[w_victim]   <= bus.refill_ppn;
         r_flags[w_victim] <= w_refill_flags;
      end
   end
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_hit   = r_resp_hit;
   assign bus.resp_ppn   = r_resp_ppn;
   assign {bus.resp_u, bus.resp_g, bus.resp_ae, bus.resp_sw, bus.resp_sx, bus.resp_sr, bus.resp_pw,
           bus.resp_px, bus.resp_pr, bus.resp_pal, bus.resp_paa, bus.resp_eff, bus.resp_c,
           bus.resp_fragmented_superpage} = r_resp_flags;
   assign bus.occupancy  = w_occupancy;
endmodule

// File: tb/tb_tlb_entry_array.sv
// tb_tlb_entry_array: directed self-checking bench for tlb_entry_array
module tb_tlb_entry_array;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   tlb_entry_array_if #(.ENTRIES(4), .VPN_BITS(20), .PPN_BITS(20)) bus ();
   tlb_entry_array #(.ENTRIES(4), .VPN_BITS(20), .PPN_BITS(20)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   function automatic logic [13:0] resp_flags();
      return {bus.resp_u, bus.resp_g, bus.resp_ae, bus.resp_sw, bus.resp_sx, bus.resp_sr, bus.resp_pw,
              bus.resp_px, bus.resp_pr, bus.resp_pal, bus.resp_paa, bus.resp_eff, bus.resp_c,
              bus.resp_fragmented_superpage};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.req_valid = 1'b0;
      bus.req_vpn = '0;
      bus.refill_valid = 1'b0;
      bus.refill_vpn = '0;
      bus.refill_ppn = '0;
      {bus.refill_u, bus.refill_g, bus.refill_ae, bus.refill_sw, bus.refill_sx, bus.refill_sr, bus.refill_pw,
       bus.refill_px, bus.refill_pr, bus.refill_pal, bus.refill_paa, bus.refill_eff, bus.refill_c,
       bus.refill_fragmented_superpage} = '0;
      bus.flush_valid = 1'b0;
      bus.flush_all = 1'b0;
      bus.flush_vpn = '0;
   endtask
   task automatic set_refill(input logic [19:0] vpn, input logic [19:0] ppn, input logic [13:0] flags);
      bus.refill_valid = 1'b1;
      bus.refill_vpn = vpn;
      bus.refill_ppn = ppn;
      {bus.refill_u, bus.refill_g, bus.refill_ae, bus.refill_sw, bus.refill_sx, bus.refill_sr, bus.refill_pw,
       bus.refill_px, bus.refill_pr, bus.refill_pal, bus.refill_paa, bus.refill_eff, bus.refill_c,
       bus.refill_fragmented_superpage} = flags;
   endtask
   task automatic refill(input logic [19:0] vpn, input logic [19:0] ppn, input logic [13:0] flags);
      set_refill(vpn, ppn, flags);
      step();
      idle();
   endtask
   task automatic check_resp(input string tag, input logic hit, input logic [19:0] ppn, input logic [13:0] flags);
      check({tag, ".valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, ".hit"}, 32'(bus.resp_hit), 32'(hit));
      check({tag, ".ppn"}, 32'(bus.resp_ppn), 32'(ppn));
      check({tag, ".flags"}, 32'(resp_flags()), 32'(flags));
   endtask
   task automatic lookup(input string tag, input logic [19:0] vpn, input logic hit, input logic [19:0] ppn,
                         input logic [13:0] flags);
      bus.req_valid = 1'b1;
      bus.req_vpn = vpn;
      step();
      idle();
      check_resp(tag, hit, ppn, flags);
   endtask
   task automatic flush(input logic all, input logic [19:0] vpn);
      bus.flush_valid = 1'b1;
      bus.flush_all = all;
      bus.flush_vpn = vpn;
      step();
      idle();
   endtask
   initial begin
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst.occ", 32'(bus.occupancy), 32'd0);
      check("rst.valid", 32'(bus.resp_valid), 32'd0);
      check("rst.hit", 32'(bus.resp_hit), 32'd0);
      check("rst.ppn", 32'(bus.resp_ppn), 32'd0);
      lookup("empty", 20'h00010, 1'b0, 20'h0, 14'h0);
      check("empty.occ", 32'(bus.occupancy), 32'd0);
      // u=bit13, pw=bit7, pr=bit5
      refill(20'h00010, 20'hABCDE, 14'h20A0);
      check("fill1.occ", 32'(bus.occupancy), 32'd1);
      lookup("hit10", 20'h00010, 1'b1, 20'hABCDE, 14'h20A0);
      step();
      check("idle.valid", 32'(bus.resp_valid), 32'd0);
      check("idle.ppn", 32'(bus.resp_ppn), 32'd0);
      set_refill(20'h00022, 20'h22222, 14'h3FFF);
      bus.req_valid = 1'b1;
      bus.req_vpn = 20'h00022;
      step();
      idle();
      check_resp("hazard", 1'b0, 20'h0, 14'h0);
      lookup("hazard_next", 20'h00022, 1'b1, 20'h22222, 14'h3FFF);
      check("hazard.occ", 32'(bus.occupancy), 32'd2);
      flush(1'b1, 20'h0);
      check("fa1.occ", 32'(bus.occupancy), 32'd0);
      for (int v = 1; v <= 4; v++) refill(20'(v), 20'(32'h100 + v), 14'h0001);
      check("full.occ", 32'(bus.occupancy), 32'd4);
      refill(20'h5, 20'h105, 14'h0);
      lookup("evict1", 20'h1, 1'b0, 20'h0, 14'h0);
      lookup("new5", 20'h5, 1'b1, 20'h105, 14'h0);
      refill(20'h6, 20'h106, 14'h0);
      lookup("evict2", 20'h2, 1'b0, 20'h0, 14'h0);
      lookup("new6", 20'h6, 1'b1, 20'h106, 14'h0);
      check("evict.occ", 32'(bus.occupancy), 32'd4);
      refill(20'h3, 20'h33, 14'h0002);
      check("inplace.occ", 32'(bus.occupancy), 32'd4);
      lookup("inplace3", 20'h3, 1'b1, 20'h33, 14'h0002);
      flush(1'b0, 20'h3);
      check("fv.occ", 32'(bus.occupancy), 32'd3);
      lookup("fv3", 20'h3, 1'b0, 20'h0, 14'h0);
      flush(1'b0, 20'h99);
      check("fvmiss.occ", 32'(bus.occupancy), 32'd3);
      // refills the freed slot (entry 2); rr_ptr must still be 2
      refill(20'h7, 20'h107, 14'h0);
      check("free.occ", 32'(bus.occupancy), 32'd4);
      refill(20'h8, 20'h108, 14'h0);
      lookup("rr_evict7", 20'h7, 1'b0, 20'h0, 14'h0);
      lookup("rr_keep4", 20'h4, 1'b1, 20'h104, 14'h0001);
      refill(20'hA, 20'h10A, 14'h0);
      refill(20'hB, 20'h10B, 14'h0);
      lookup("wrap_evict4", 20'h4, 1'b0, 20'h0, 14'h0);
      lookup("wrap_evict5", 20'h5, 1'b0, 20'h0, 14'h0);
      lookup("wrap_keep6", 20'h6, 1'b1, 20'h106, 14'h0);
      check("wrap.occ", 32'(bus.occupancy), 32'd4);
      set_refill(20'h7, 20'h777, 14'h0);
      bus.flush_valid = 1'b1;
      bus.flush_all = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_vpn = 20'h6;
      step();
      idle();
      check_resp("fa_same", 1'b1, 20'h106, 14'h0);
      check("fa2.occ", 32'(bus.occupancy), 32'd0);
      lookup("fa_drop7", 20'h7, 1'b0, 20'h0, 14'h0);
      lookup("fa_gone6", 20'h6, 1'b0, 20'h0, 14'h0);
      refill(20'h40, 20'h444, 14'h0);
      bus.req_valid = 1'b1;
      bus.req_vpn = 20'h40;
      rst = 1'b1;
      step();
      idle();
      rst = 1'b0;
      check("mrst.valid", 32'(bus.resp_valid), 32'd0);
      check("mrst.hit", 32'(bus.resp_hit), 32'd0);
      check("mrst.occ", 32'(bus.occupancy), 32'd0);
      lookup("mrst40", 20'h40, 1'b0, 20'h0, 14'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
